fm3_stream_out: RTL

//  Reader/serializer at the output end of the third convolution stage. Captures the

---
 rtl/lenet_pkg.sv | 10 +
 rtl/fm3_argmax_tracker.sv | 48 ++++
 rtl/fm3_stream_out.sv | 95 +++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared widths, score type and stream FSM states for the LeNet output stage.
package lenet_pkg;
  localparam int BITWIDTH    = 32;
  localparam int NUM_CLASSES = 10;
  localparam int CLS_IDX_W   = $clog2(NUM_CLASSES);

  typedef logic signed [BITWIDTH-1:0] score_t;

  typedef enum logic {IDLE, STREAM} fm3_state_e;
endpackage

// File: rtl/fm3_argmax_tracker.sv
// Running signed maximum over the streamed class scores; ties keep the lowest index.
// Instantiated by fm3_stream_out only when FM3_ARGMAX_EN is defined.
module fm3_argmax_tracker #(
  parameter int W  = lenet_pkg::BITWIDTH,
  parameter int IW = lenet_pkg::CLS_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                sample,
  input  logic [IW-1:0]       index,
  input  logic signed [W-1:0] value,
  input  logic                done,
  output logic                argmax_valid,
  output logic [IW-1:0]       argmax_index,
  output logic signed [W-1:0] argmax_value
);
  logic                r_valid;
  logic [IW-1:0]       r_max_idx;
  logic signed [W-1:0] r_max_val;
  logic                w_take;

  // Word 0 seeds the maximum; later words must be strictly greater to win.
  assign w_take = sample && ((index == '0) || (value > r_max_val));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_max_idx <= '0;
      r_max_val <= '0;
    end else begin
      r_valid <= done;
      if (clear) begin
        r_max_idx <= '0;
        r_max_val <= '0;
      end else if (w_take) begin
        r_max_idx <= index;
        r_max_val <= value;
      end
    end
  end

  assign argmax_valid = r_valid;
  assign argmax_index = r_max_idx;
  assign argmax_value = r_max_val;
endmodule

// File: rtl/fm3_stream_out.sv
// Captures the conv-3 class-score vector in one cycle and streams it out index 0 first
// over valid/ready with a last flag. Define FM3_ARGMAX_EN to add the argmax_* outputs.
module fm3_stream_out #(
  parameter int bitwidth    = lenet_pkg::BITWIDTH,
  parameter int NUM_CLASSES = lenet_pkg::NUM_CLASSES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fm_valid,
  output logic                                fm_ready,
  input  logic signed [bitwidth-1:0]          featuremap3 [NUM_CLASSES-1:0],
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic signed [bitwidth-1:0]          m_data,
  output logic [$clog2(NUM_CLASSES)-1:0]      m_index,
  output logic                                m_last,
  output logic                                busy
`ifdef FM3_ARGMAX_EN
  ,
  output logic                                argmax_valid,
  output logic [$clog2(NUM_CLASSES)-1:0]      argmax_index,
  output logic signed [bitwidth-1:0]          argmax_value
`endif
);
  import lenet_pkg::*;

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  fm3_state_e                r_state, w_state_nxt;
  logic signed [bitwidth-1:0] r_buf [NUM_CLASSES-1:0];
  logic [IDX_W-1:0]          r_idx;
  logic                      w_stream, w_capture, w_accept, w_last;

  assign w_stream  = (r_state == STREAM);
  assign w_capture = fm_valid && fm_ready;
  assign w_last    = w_stream && (r_idx == LAST_IDX);
  assign w_accept  = w_stream && m_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves the
  // next state unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (fm_valid)           w_state_nxt = STREAM;
      STREAM:  if (w_accept && w_last) w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  // Index stops at the last word; it is reloaded on the next capture.
  always_ff @(posedge clk) begin
    if (rst)                       r_idx <= '0;
    else if (w_capture)            r_idx <= '0;
    else if (w_accept && !w_last)  r_idx <= r_idx + 1'b1;
  end

  // NOTE: the shadow buffer has no reset; its contents are only observable
  // in STREAM, which is reachable only through a capture that overwrites it.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_buf[i] <= featuremap3[i];
    end
  end

  assign fm_ready = !w_stream;
  assign busy     = w_stream;
  assign m_valid  = w_stream;
  assign m_data   = w_stream ? r_buf[r_idx] : '0;
  assign m_index  = w_stream ? r_idx : '0;
  assign m_last   = w_last;

`ifdef FM3_ARGMAX_EN
  fm3_argmax_tracker #(
    .W  (bitwidth),
    .IW (IDX_W)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .clear        (w_capture),
    .sample       (w_accept),
    .index        (r_idx),
    .value        (r_buf[r_idx]),
    .done         (w_accept && w_last),
    .argmax_valid (argmax_valid),
    .argmax_index (argmax_index),
    .argmax_value (argmax_value)
  );
`endif
endmodule
